seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 63 ++++++
 rtl/seg_hex_rom.sv | 16 +
 rtl/seven_seg_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the seven-segment display path.
//   SEG_BLANK       : all segments off (active-low pattern)
//   SEG_A .. SEG_G  : bit positions of each segment inside a 7-bit pattern;
//                     A is the MSB and G is the LSB
//   HEX_0 .. HEX_F  : active-low segment patterns for each hex digit
//   hex_to_seg()    : nibble -> active-low segment pattern
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] HEX_0 = 7'b0000001;
    localparam logic [6:0] HEX_1 = 7'b1001111;
    localparam logic [6:0] HEX_2 = 7'b0010010;
    localparam logic [6:0] HEX_3 = 7'b0000110;
    localparam logic [6:0] HEX_4 = 7'b1001100;
    localparam logic [6:0] HEX_5 = 7'b0100100;
    localparam logic [6:0] HEX_6 = 7'b0100000;
    localparam logic [6:0] HEX_7 = 7'b0001111;
    localparam logic [6:0] HEX_8 = 7'b0000000;
    localparam logic [6:0] HEX_9 = 7'b0000100;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_B = 7'b1100000;
    localparam logic [6:0] HEX_C = 7'b0110001;
    localparam logic [6:0] HEX_D = 7'b1000010;
    localparam logic [6:0] HEX_E = 7'b0110000;
    localparam logic [6:0] HEX_F = 7'b0111000;

    // Lower-case b and d are used so they cannot be confused with 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = HEX_0;
            4'h1:    pattern = HEX_1;
            4'h2:    pattern = HEX_2;
            4'h3:    pattern = HEX_3;
            4'h4:    pattern = HEX_4;
            4'h5:    pattern = HEX_5;
            4'h6:    pattern = HEX_6;
            4'h7:    pattern = HEX_7;
            4'h8:    pattern = HEX_8;
            4'h9:    pattern = HEX_9;
            4'hA:    pattern = HEX_A;
            4'hB:    pattern = HEX_B;
            4'hC:    pattern = HEX_C;
            4'hD:    pattern = HEX_D;
            4'hE:    pattern = HEX_E;
            default: pattern = HEX_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_hex_rom.sv
// ---------------------------------------------------------------------------
// seg_hex_rom
// Purely combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low segment pattern {A,B,C,D,E,F,G}
// ---------------------------------------------------------------------------
module seg_hex_rom
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// A loaded value is parked in a pending buffer and only becomes visible at
// the next frame boundary, so a frame never shows a mix of old and new data.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : one-cycle strobe capturing value and dp_in
//   value       : packed hex nibbles, nibble 0 is the rightmost digit
//   dp_in       : decimal-point request per digit (1 = lit)
//   blank_lz    : blank leading zero digits (live, not captured)
//   seg         : active-low segments {A..G}
//   dp_n        : active-low decimal point
//   an_n        : active-low digit enables, at most one low
//   frame_start : one-cycle pulse when digit 0's slot begins
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   pending_value;
    logic [NUM_DIGITS-1:0]     pending_dp;
    logic                      pending_valid;
    logic [4*NUM_DIGITS-1:0]   active_value;
    logic [NUM_DIGITS-1:0]     active_dp;

    logic                      slot_end;
    logic                      frame_end;
    logic [3:0]                sel_nibble;
    logic                      sel_dp;
    logic                      sel_lz;
    logic                      higher_zero;
    logic [NUM_DIGITS-1:0]     an_next;
    logic [6:0]                rom_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Slot counter and digit index. With a single digit IDX_LAST is 0, so
    // idx stays put and every slot end is also a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer. A load landing exactly on the frame edge bypasses the
    // pending stage so it is not held back a whole extra frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_value <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            active_value  <= '0;
            active_dp     <= '0;
        end else if (frame_end) begin
            if (load) begin
                active_value <= value;
                active_dp    <= dp_in;
            end else if (pending_valid) begin
                active_value <= pending_value;
                active_dp    <= pending_dp;
            end
            pending_valid <= 1'b0;
        end else if (load) begin
            pending_value <= value;
            pending_dp    <= dp_in;
            pending_valid <= 1'b1;
        end
    end

    // Select the current digit's nibble and dp bit, decide whether it is a
    // leading zero (scanning from the top nibble down), and build the
    // one-cold anode vector. Digit 0 is never treated as a leading zero.
    always_comb begin
        sel_nibble  = 4'h0;
        sel_dp      = 1'b0;
        sel_lz      = 1'b0;
        higher_zero = 1'b1;
        an_next     = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (active_value[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                sel_nibble = active_value[4*i +: 4];
                sel_dp     = active_dp[i];
                sel_lz     = higher_zero && (i > 0);
                an_next[i] = 1'b0;
            end
        end
    end

    seg_hex_rom u_rom (
        .nibble (sel_nibble),
        .seg    (rom_seg)
    );

    // Registered outputs. Segments are driven through the dead time too;
    // only the anodes are held off to stop the previous digit ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            if (blank_lz && sel_lz) begin
                seg  <= SEG_BLANK;
                dp_n <= 1'b1;
            end else begin
                seg  <= rom_seg;
                dp_n <= ~sel_dp;
            end
            an_n        <= (cnt < CNT_DEAD) ? '1 : an_next;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_driver
// Self-checking bench for seven_seg_scan_driver with a small configuration
// (4 digits, 8-cycle slots, 2 dead cycles). The reference model describes
// the display in terms of elapsed clock edges: slot position and digit come
// from division/modulo of the edge count, and the displayed value changes
// only on edges that are whole multiples of the frame length.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int R     = 8;
    localparam int D     = 2;
    localparam int FRAME = N * R;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [6:0]    seg;
    logic          dp_n;
    logic [3:0]    an_n;
    logic          frame_start;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .DEAD_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int           edges;
    logic [15:0]  m_act_val;
    logic [3:0]   m_act_dp;
    logic [15:0]  m_pend_val;
    logic [3:0]   m_pend_dp;
    logic         m_pend_valid;
    logic [6:0]   exp_seg;
    logic         exp_dp;
    logic [3:0]   exp_an;
    logic         exp_fs;

    logic [6:0] hex_table [16];

    initial begin
        hex_table[0]  = 7'b0000001; hex_table[1]  = 7'b1001111;
        hex_table[2]  = 7'b0010010; hex_table[3]  = 7'b0000110;
        hex_table[4]  = 7'b1001100; hex_table[5]  = 7'b0100100;
        hex_table[6]  = 7'b0100000; hex_table[7]  = 7'b0001111;
        hex_table[8]  = 7'b0000000; hex_table[9]  = 7'b0000100;
        hex_table[10] = 7'b0001000; hex_table[11] = 7'b1100000;
        hex_table[12] = 7'b0110001; hex_table[13] = 7'b1000010;
        hex_table[14] = 7'b0110000; hex_table[15] = 7'b0111000;
    end

    task automatic model_reset();
        edges        = 0;
        m_act_val    = '0;
        m_act_dp     = '0;
        m_pend_val   = '0;
        m_pend_dp    = '0;
        m_pend_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the outputs that appear after the
    // coming edge, advance the model, then wait until just after that edge.
    task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic blz);
        int pos;
        int dig;
        logic [15:0] upper;
        logic blanked;
        load     = ld;
        value    = v;
        dp_in    = d;
        blank_lz = blz;
        pos      = edges % R;
        dig      = (edges / R) % N;
        upper    = m_act_val >> (4 * dig);
        blanked  = blz && (dig > 0) && (upper == 16'h0);
        exp_an   = (pos < D) ? 4'hF : ~(4'b0001 << dig);
        exp_seg  = blanked ? 7'b1111111 : hex_table[upper[3:0]];
        exp_dp   = blanked ? 1'b1 : ~m_act_dp[dig];
        edges    = edges + 1;
        exp_fs   = (edges % FRAME) == 0;
        if ((edges % FRAME) == 0) begin
            if (ld) begin
                m_act_val = v;
                m_act_dp  = d;
            end else if (m_pend_valid) begin
                m_act_val = m_pend_val;
                m_act_dp  = m_pend_dp;
            end
            m_pend_valid = 1'b0;
        end else if (ld) begin
            m_pend_val   = v;
            m_pend_dp    = d;
            m_pend_valid = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic align_to(input int phase, input logic blz);
        for (int i = 0; i < FRAME && (edges % FRAME) != phase; i++)
            tick(1'b0, 16'h0, 4'h0, blz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++)
            tick(i == 2, 16'h8888, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (seg !== 7'b1111111 || dp_n !== 1'b1 || an_n !== 4'hF || frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_async: seg=%b dp_n=%b an_n=%b fs=%b, expected 1111111 1 1111 0",
                     seg, dp_n, an_n, frame_start);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (seg !== 7'b1111111 || dp_n !== 1'b1 || an_n !== 4'hF || frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_hold: seg=%b dp_n=%b an_n=%b fs=%b, expected 1111111 1 1111 0",
                     seg, dp_n, an_n, frame_start);
        end
        tests++;
        if (dut.pending_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_pending: pending_valid=%b, expected 0", dut.pending_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_decode();
        tick(1'b1, 16'hFEDB, 4'h0, 1'b0);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            tests++;
            if (seg !== exp_seg || dp_n !== exp_dp || an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL decode edge %0d: got seg=%b dp_n=%b an_n=%b fs=%b, expected seg=%b dp_n=%b an_n=%b fs=%b",
                         edges, seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            end
        end
    endtask

    task automatic test_scan_timing();
        int last_fs;
        int gap_bad;
        last_fs = -1;
        gap_bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            tests++;
            if (an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL scan edge %0d: got an_n=%b fs=%b, expected an_n=%b fs=%b",
                         edges, an_n, frame_start, exp_an, exp_fs);
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0 && (edges - last_fs) != FRAME) gap_bad++;
                last_fs = edges;
            end
        end
        tests++;
        if (gap_bad != 0 || last_fs < 0) begin
            fails++;
            $display("[TB] FAIL frame_period: bad gaps=%0d last pulse edge=%0d, expected 0 bad gaps every %0d",
                     gap_bad, last_fs, FRAME);
        end
    endtask

    task automatic test_blanking();
        tick(1'b1, 16'h0050, 4'b1100, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b1);
            tests++;
            if (seg !== exp_seg || dp_n !== exp_dp || an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL blanking edge %0d: got seg=%b dp_n=%b an_n=%b fs=%b, expected seg=%b dp_n=%b an_n=%b fs=%b",
                         edges, seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            end
        end
    endtask

    task automatic test_tearing();
        int seen_one;
        seen_one = 0;
        align_to(5, 1'b0);
        tick(1'b1, 16'h1111, 4'h0, 1'b0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick((edges % FRAME) == 20 && i < FRAME, 16'h2222, 4'h0, 1'b0);
            tests++;
            if (seg !== exp_seg || dp_n !== exp_dp || an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL tearing edge %0d: got seg=%b dp_n=%b an_n=%b fs=%b, expected seg=%b dp_n=%b an_n=%b fs=%b",
                         edges, seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            end
            if (seg === 7'b1001111) seen_one++;
        end
        tests++;
        if (seen_one != 0) begin
            fails++;
            $display("[TB] FAIL tearing_overwritten: cycles showing 1 = %0d, expected 0", seen_one);
        end
    endtask

    task automatic test_boundary_collision();
        int checked_digit0;
        checked_digit0 = 0;
        align_to(10, 1'b0);
        tick(1'b1, 16'h4444, 4'h0, 1'b0);
        align_to(FRAME - 1, 1'b0);
        tick(1'b1, 16'h3333, 4'h0, 1'b0);
        tests++;
        if (dut.pending_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL collision_pending: pending_valid=%b, expected 0", dut.pending_valid);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 16'h0, 4'h0, 1'b0);
            tests++;
            if (seg !== exp_seg || dp_n !== exp_dp || an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL collision edge %0d: got seg=%b dp_n=%b an_n=%b fs=%b, expected seg=%b dp_n=%b an_n=%b fs=%b",
                         edges, seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            end
            if (checked_digit0 == 0 && an_n === 4'b1110) begin
                checked_digit0 = 1;
                tests++;
                if (seg !== 7'b0000110) begin
                    fails++;
                    $display("[TB] FAIL collision_first_frame: seg=%b, expected 0000110", seg);
                end
            end
        end
    endtask

    task automatic test_random();
        logic blz;
        blz = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ((i % 16) == 0) blz = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 9) == 0, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                 4'($urandom), blz);
            tests++;
            if (seg !== exp_seg || dp_n !== exp_dp || an_n !== exp_an || frame_start !== exp_fs) begin
                fails++;
                $display("[TB] FAIL random edge %0d: got seg=%b dp_n=%b an_n=%b fs=%b, expected seg=%b dp_n=%b an_n=%b fs=%b",
                         edges, seg, dp_n, an_n, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        test_reset();
        test_decode();
        test_scan_timing();
        test_blanking();
        test_tearing();
        test_boundary_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
